// File: rtl/boundary_line_reader.sv
// ============================================================================
// boundary_line_reader: fetches a boundary row per scanline, double-buffers
// it, classifies active pixels and owns the vblank-aligned scroll toggle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module boundary_line_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        scroll_req,
  input  logic [39:0] dataout,
  output logic [8:0]  readaddress,
  output logic        shift,
  output logic [1:0]  pixel_class,
  output logic        row_valid
);

  localparam logic [9:0] c_h_active    = 10'(H_ACTIVE);
  localparam logic [9:0] c_h_last      = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_active    = 10'(V_ACTIVE);
  localparam logic [9:0] c_v_fetch_end = 10'(V_ACTIVE - 1);
  localparam logic [9:0] c_v_last      = 10'(V_TOTAL - 1);
  localparam logic [7:0] c_wait_init   = 8'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [39:0] r_next_row;
  logic        r_next_ok;
  logic [39:0] r_cur_row;
  logic        r_pending;

  logic       w_fetch_line;
  logic [8:0] w_target;
  logic [9:0] w_bank_l, w_bank_r, w_isl_l, w_isl_r;
  logic       w_active, w_water, w_island;

  // Line V_TOTAL-1 prefetches row 0 for the first line of the next frame.
  assign w_fetch_line = (vcount < c_v_fetch_end) || (vcount == c_v_last);
  assign w_target     = (vcount == c_v_last) ? 9'd0 : (vcount[8:0] + 9'd1);

  assign w_bank_l = r_cur_row[39:30];
  assign w_bank_r = r_cur_row[29:20];
  assign w_isl_l  = r_cur_row[19:10];
  assign w_isl_r  = r_cur_row[9:0];

  // Empty intervals (left >= right) fall out of the range compares naturally.
  assign w_active = (hcount < c_h_active) && (vcount < c_v_active);
  assign w_water  = (w_bank_l <= hcount) && (hcount < w_bank_r);
  assign w_island = w_water && (w_isl_l < w_isl_r) &&
                    (w_isl_l <= hcount) && (hcount < w_isl_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 8'd0;
      r_next_row  <= 40'd0;
      r_next_ok   <= 1'b0;
      r_cur_row   <= 40'd0;
      r_pending   <= 1'b0;
      readaddress <= 9'd0;
      shift       <= 1'b0;
      pixel_class <= 2'd0;
      row_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hcount == c_h_active && w_fetch_line) begin
            readaddress <= w_target;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_wait_cnt <= c_wait_init;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt != 8'd0) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
          if (r_wait_cnt <= 8'd1) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_next_row <= dataout;
          r_next_ok  <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (hcount == c_h_last) begin
        if (r_next_ok) begin
          r_cur_row <= r_next_row;
          row_valid <= 1'b1;
          r_next_ok <= 1'b0;
        end else begin
          r_cur_row <= 40'd0;
          row_valid <= 1'b0;
        end
      end

      if (!w_active) begin
        pixel_class <= 2'd0;
      end else if (w_island) begin
        pixel_class <= 2'd2;
      end else if (w_water) begin
        pixel_class <= 2'd1;
      end else begin
        pixel_class <= 2'd0;
      end

      // A request landing in the toggle cycle is absorbed by that toggle.
      if (hcount == 10'd0 && vcount == c_v_active) begin
        if (r_pending || scroll_req) begin
          shift     <= ~shift;
          r_pending <= 1'b0;
        end
      end else if (scroll_req) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/boundary_line_reader.md
Name: boundary_line_reader

Overview:
- Display-side consumer of the boundary ring memory.
- Once per scanline, during horizontal blanking, fetches the 40-bit boundary row for the next line and double-buffers it.
- Classifies each active pixel as land, water or island.
- Owns the scroll `shift` toggle, so the ring memory advances only during vertical blanking and no frame shows a torn scroll.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, total hcount values per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, total vcount values per frame
- READ_LATENCY, 2, clocks from readaddress stable to dataout valid

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- hcount  in  10  current pixel column, 0..H_TOTAL-1
- vcount  in  10  current line, 0..V_TOTAL-1
- scroll_req  in  1  one-cycle pulse: advance river by one row
- dataout  in  40  boundary row from ring memory
- readaddress  out  9  row index to ring memory
- shift  out  1  level toggled once per scroll step
- pixel_class  out  2  0=land, 1=water, 2=island, 3=unused
- row_valid  out  1  cur_row holds a fetched row

Behaviour:
- Row format:
  - [39:30] bank_l
  - [29:20] bank_r
  - [19:10] isl_l
  - [9:0] isl_r
  - All fields are unsigned pixel x.
- Fetch FSM states: IDLE, ADDR, WAIT, CAPTURE.
  - IDLE -> ADDR when hcount==H_ACTIVE and vcount is in a fetch line.
  - Fetch lines are vcount<V_ACTIVE-1 (fetches row vcount+1) and vcount==V_TOTAL-1 (fetches row 0). No fetch on any other line.
  - ADDR: drive readaddress with the target row; load wait counter with READ_LATENCY-1.
  - WAIT: decrement the counter; readaddress held stable; go to CAPTURE at 0.
  - CAPTURE: next_row <= dataout; next_ok <= 1; -> IDLE.
  - readaddress changes only on entry to ADDR. Reset value 0.
- Line swap: at hcount==H_TOTAL-1:
  - if next_ok: cur_row <= next_row, row_valid <= 1, next_ok <= 0;
  - else: cur_row <= 0, row_valid <= 0.
- Classification, registered, latency 1 clock from hcount:
  - water iff bank_l<=x<bank_r.
  - island iff water and isl_l<isl_r and isl_l<=x<isl_r; island overrides water.
  - Otherwise land.
  - Outside active video (hcount>=H_ACTIVE or vcount>=V_ACTIVE) the output is 0.
  - A row with bank_l>=bank_r is all land.
  - A row with isl_l>=isl_r has no island.
- Scroll:
  - scroll_req sets pending; pending saturates at 1, so extra requests in one frame are dropped.
  - At hcount==0 and vcount==V_ACTIVE: if pending or scroll_req that cycle, toggle shift and clear pending. A request in the toggle cycle is consumed by that toggle.
  - At most one toggle per frame.
- Reset, any cycle including mid-fetch:
  - FSM -> IDLE.
  - readaddress=0, shift=0, pending=0, next_ok=0, cur_row=0.
  - row_valid=0, pixel_class=0.
  - An aborted fetch is discarded; that line renders land.
- READ_LATENCY must be >=1. A fetch completes within READ_LATENCY+2 clocks, well inside hblank.

Test Plan:
- Fetch timing: dataout follows readaddress with 2-clock delay; vcount=9, hcount=640 -> readaddress=10 for exactly 3 clocks; next_row captured on the 4th clock; row_valid=1 after hcount=799.
- Classify: cur_row bank_l=100, bank_r=300, isl_l=180, isl_r=220:
  - x=99 -> 0
  - x=100 -> 1
  - x=180 -> 2
  - x=219 -> 2
  - x=220 -> 1
  - x=300 -> 0
  - Each value appears one clock after its hcount.
- Degenerate rows:
  - bank_l=300, bank_r=100 -> all land.
  - isl_l=isl_r=200 -> no class 2 anywhere.
- Scroll: three scroll_req pulses at vcount=50 -> shift toggles exactly once at (vcount=480, hcount=0); no toggle in the following frame without a new request.
- Frame wrap: vcount=524, hcount=640 -> readaddress=0; vcount=479 -> no fetch, so line 480 does not get a valid row.
- Reset mid-fetch: reset asserted during WAIT -> all outputs 0 next clock; the line after reset shows pixel_class=0 and row_valid=0; normal fetch resumes at the next fetch line.
